// File: rtl/pico_timer_n_if.sv
// pico_timer_n_if: PicoBlaze port bus between the processor (master) and the timer bank (slave).
interface pico_timer_n_if;
    logic [7:0] port_id;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       write_strobe;
    logic       read_strobe;
    logic       interrupt;
    modport master(output port_id, data_in, write_strobe, read_strobe, input data_out, interrupt);
    modport slave(input port_id, data_in, write_strobe, read_strobe, output data_out, interrupt);
endinterface

// File: rtl/pico_timer_n.sv
// pico_timer_n: bank of down-counting timers on a PicoBlaze port window.
// PICO_TIMER_PRESCALER_EN adds the shared PRESCALE register; without it every cycle is a tick.
module pico_timer_n #(
    parameter logic [7:0] BASE_ADDRESS = 8'h00,
    parameter int         NUM_TIMERS   = 2,
    parameter int         COUNT_WIDTH  = 16
) (
    input logic           clk,
    input logic           reset,
    pico_timer_n_if.slave bus
);
    localparam int NB = COUNT_WIDTH / 8;
    logic [8:0] off;
    logic [3:0] k;
    logic prescale_sel, tick;
    logic [7:0] prescale_rd, rd;
    logic [NUM_TIMERS-1:0] sel, load, exp_now, enable, irq_en, periodic, expired;
    logic [COUNT_WIDTH-1:0] reload [NUM_TIMERS];
    logic [COUNT_WIDTH-1:0] count [NUM_TIMERS];
    logic [COUNT_WIDTH-1:0] snap [NUM_TIMERS];

    // 9-bit offset so ports below the base come out negative instead of wrapping into the window
    assign off = {1'b0, bus.port_id} - {1'b0, BASE_ADDRESS};
    assign k = off[3:0];
    assign prescale_sel = off == 9'(16 * NUM_TIMERS);

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
        assign sel[i] = !off[8] && off[7:4] == 4'(i);
        assign load[i] = bus.write_strobe && sel[i] && k == 4'd0 && bus.data_in[3];
        assign exp_now[i] = tick && enable[i] && !load[i] && count[i] == '0;
    end

`ifdef PICO_TIMER_PRESCALER_EN
    logic [7:0] prescale, pcnt;
    assign tick = pcnt == prescale;
    assign prescale_rd = prescale;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale <= '0;
            pcnt <= '0;
        end else if (bus.write_strobe && prescale_sel) begin
            prescale <= bus.data_in;
            pcnt <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + 8'd1;
        end
    end
`else
    assign tick = 1'b1;
    assign prescale_rd = 8'h00;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable <= '0;
            irq_en <= '0;
            periodic <= '0;
            expired <= '0;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                reload[i] <= '0;
                count[i] <= '0;
                snap[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (bus.read_strobe && sel[i] && k == 4'd6)
                    snap[i] <= count[i];
                if (exp_now[i]) begin
                    expired[i] <= 1'b1;
                    if (periodic[i]) count[i] <= reload[i];
                    else enable[i] <= 1'b0;
                end else if (tick && enable[i] && !load[i]) begin
                    count[i] <= count[i] - COUNT_WIDTH'(1);
                end
                // register writes come last so they override the tick update of the same cycle
                if (bus.write_strobe && sel[i]) begin
                    if (k == 4'd0) {periodic[i], irq_en[i], enable[i]} <= bus.data_in[2:0];
                    if (load[i]) count[i] <= reload[i];
                    if (k == 4'd1 && bus.data_in[0] && !exp_now[i]) expired[i] <= 1'b0;
                    for (int j = 0; j < NB; j++)
                        if (k == 4'(j + 2)) reload[i][8*j +: 8] <= bus.data_in;
                end
            end
        end
    end

    always_comb begin
        rd = prescale_sel ? prescale_rd : 8'h00;
        for (int i = 0; i < NUM_TIMERS; i++)
            if (sel[i])
                rd = k == 4'd0 ? {5'b0, periodic[i], irq_en[i], enable[i]} :
                     k == 4'd1 ? {6'b0, enable[i], expired[i]} :
                     k inside {[2:5]} ? 8'(32'(reload[i]) >> {k - 4'd2, 3'b000}) :
                     k == 4'd6 ? count[i][7:0] :
                     k inside {[7:9]} ? 8'(32'(snap[i]) >> {k - 4'd6, 3'b000}) : 8'h00;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.data_out <= '0;
            bus.interrupt <= 1'b0;
        end else begin
            bus.data_out <= rd;
            bus.interrupt <= |(expired & irq_en);
        end
    end
endmodule

// File: tb/tb_pico_timer_n.sv
// tb_pico_timer_n: randomized scoreboard bench for pico_timer_n against a behavioural register/timer model.
module tb_pico_timer_n;
    localparam logic [7:0] BASE = 8'h10;
    localparam int N = 2;
    localparam int CW = 16;
    localparam int NB = CW / 8;

    typedef struct { logic [7:0] d; logic irq; } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    pico_timer_n_if bus();
    pico_timer_n #(.BASE_ADDRESS(BASE), .NUM_TIMERS(N), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    always #5 clk = ~clk;

    exp_t q[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    int m_en[N], m_ie[N], m_per[N], m_exp[N];
    longint m_rl[N], m_cnt[N], m_sn[N];
    int m_ps, m_sc;

    function automatic logic [7:0] a(input int c, input int k);
        return 8'(int'(BASE) + 16 * c + k);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_en[i] = 0; m_ie[i] = 0; m_per[i] = 0; m_exp[i] = 0;
            m_rl[i] = 0; m_cnt[i] = 0; m_sn[i] = 0;
        end
        m_ps = 0;
        m_sc = 0;
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] p);
        int off = int'(p) - int'(BASE);
        int c = off / 16;
        int k = off % 16;
        if (off < 0) return 8'h00;
        if (off == 16 * N) begin
`ifdef PICO_TIMER_PRESCALER_EN
            return 8'(m_ps);
`else
            return 8'h00;
`endif
        end
        if (off > 16 * N) return 8'h00;
        case (k)
            0: return 8'(m_per[c] * 4 + m_ie[c] * 2 + m_en[c]);
            1: return 8'(m_en[c] * 2 + m_exp[c]);
            2, 3, 4, 5: return 8'(m_rl[c] >> (8 * (k - 2)));
            6: return 8'(m_cnt[c]);
            7, 8, 9: return 8'(m_sn[c] >> (8 * (k - 6)));
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic model_irq();
        for (int i = 0; i < N; i++)
            if (m_exp[i] != 0 && m_ie[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock edge of the register file and timers, as described by the register map
    task automatic model_step(input logic [7:0] p, input logic [7:0] d, input bit wr, input bit rd);
        int off = int'(p) - int'(BASE);
        int k = off % 16;
        bit tick, sel, load, exp_now;
`ifdef PICO_TIMER_PRESCALER_EN
        tick = (m_sc % (m_ps + 1)) == m_ps;
`else
        tick = 1'b1;
`endif
        for (int i = 0; i < N; i++) begin
            sel = off >= 0 && off < 16 * N && off / 16 == i;
            load = wr && sel && k == 0 && d[3];
            exp_now = 1'b0;
            if (rd && sel && k == 6) m_sn[i] = m_cnt[i];
            if (tick && m_en[i] != 0 && !load) begin
                if (m_cnt[i] != 0) m_cnt[i]--;
                else begin
                    m_exp[i] = 1;
                    exp_now = 1'b1;
                    if (m_per[i] != 0) m_cnt[i] = m_rl[i];
                    else m_en[i] = 0;
                end
            end
            if (wr && sel) begin
                if (k == 0) begin
                    m_en[i] = int'(d[0]); m_ie[i] = int'(d[1]); m_per[i] = int'(d[2]);
                    if (d[3]) m_cnt[i] = m_rl[i];
                end
                if (k == 1 && d[0] && !exp_now) m_exp[i] = 0;
                if (k >= 2 && k <= 5 && k - 2 < NB)
                    m_rl[i] = (m_rl[i] & ~(longint'(255) << (8 * (k - 2)))) | (longint'(d) << (8 * (k - 2)));
            end
        end
`ifdef PICO_TIMER_PRESCALER_EN
        if (wr && off == 16 * N) begin
            m_ps = int'(d);
            m_sc = 0;
        end else m_sc++;
`else
        m_sc++;
`endif
    endtask

    task automatic drive(input logic [7:0] p, input logic [7:0] d, input bit wr, input bit rd);
        exp_t e;
        bus.port_id = p;
        bus.data_in = d;
        bus.write_strobe = wr;
        bus.read_strobe = rd;
        e.d = model_read(p);
        e.irq = model_irq();
        q.push_back(e);
        model_step(p, d, wr, rd);
    endtask

    task automatic step(input logic [7:0] p, input logic [7:0] d, input bit wr, input bit rd);
        @(negedge clk);
        drive(p, d, wr, rd);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        mon_en = 1'b0;
        q.delete();
        reset = 1'b0;
        #1;
        check("async_reset data_out", bus.data_out, 8'h00);
        check("async_reset interrupt", 8'(bus.interrupt), 8'h00);
        model_reset();
        repeat (cycles) @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b1;
        drive(a(0, 1), 8'h00, 1'b0, 1'b0);
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en && q.size() > 0) begin
            mon_e = q.pop_front();
            check("data_out", bus.data_out, mon_e.d);
            check("interrupt", 8'(bus.interrupt), 8'(mon_e.irq));
        end
    end

    initial begin
        logic [7:0] p, d;
        int k;
        bus.port_id = 8'h00;
        bus.data_in = 8'h00;
        bus.write_strobe = 1'b0;
        bus.read_strobe = 1'b0;
        model_reset();
        do_reset(3);
        // periodic reload 5
        step(a(0, 2), 8'h05, 1, 0); step(a(0, 3), 8'h00, 1, 0); step(a(0, 0), 8'h0D, 1, 0);
        repeat (14) step(a(0, 6), 8'h00, 0, 0);
        // one-shot with interrupt, then clear
        step(a(1, 2), 8'h03, 1, 0); step(a(1, 0), 8'h0B, 1, 0);
        repeat (8) step(a(1, 1), 8'h00, 0, 0);
        step(a(1, 1), 8'h01, 1, 0);
        repeat (3) step(a(1, 1), 8'h00, 0, 0);
        // prescaled periodic reload 2
        step(a(N, 0), 8'h03, 1, 0); step(a(0, 2), 8'h02, 1, 0); step(a(0, 0), 8'h0D, 1, 0);
        repeat (3) begin
            repeat (12) step(a(0, 1), 8'h00, 0, 0);
            step(a(0, 1), 8'h01, 1, 0);
        end
        step(a(N, 0), 8'h00, 1, 0);
        // snapshot of 16'h1200
        step(a(0, 2), 8'h00, 1, 0); step(a(0, 3), 8'h12, 1, 0); step(a(0, 0), 8'h0D, 1, 0);
        step(a(0, 6), 8'h00, 0, 1);
        repeat (3) step(a(0, 6), 8'h00, 0, 0);
        step(a(0, 7), 8'h00, 0, 1); step(a(0, 7), 8'h00, 0, 0);
        // reload 0 periodic, clear attempt on an expiry cycle
        step(a(0, 3), 8'h00, 1, 0); step(a(0, 2), 8'h00, 1, 0); step(a(0, 0), 8'h0D, 1, 0);
        repeat (3) step(a(0, 1), 8'h00, 0, 0);
        step(a(0, 1), 8'h01, 1, 0);
        repeat (3) step(a(0, 1), 8'h00, 0, 0);
        // reset mid-count of 16'h00FF
        step(a(0, 2), 8'hFF, 1, 0); step(a(0, 0), 8'h0F, 1, 0); step(a(1, 0), 8'h07, 1, 0);
        repeat (10) step(a(0, 6), 8'h00, 0, 0);
        do_reset(3);
        for (int c = 0; c < N; c++) begin
            step(a(c, 0), 8'h00, 0, 0);
            step(a(c, 1), 8'h00, 0, 0);
        end
        // random traffic
        for (int n = 0; n < 3000; n++) begin
            int c = $urandom_range(0, N);
            if (n == 1500) do_reset(2);
            if ($urandom_range(0, 99) < 3) p = 8'($urandom);
            else if (c == N) p = a(N, 0);
            else p = a(c, $urandom_range(0, 10));
            k = int'(p) - int'(BASE);
            d = 8'($urandom);
            if (k >= 0 && k % 16 >= 3 && k % 16 <= 5 && $urandom_range(0, 3) != 0) d = 8'h00;
            if (k == 16 * N) d = 8'($urandom_range(0, 3));
            step(p, d, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        end
        repeat (3) step(a(0, 1), 8'h00, 0, 0);
        @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pico_timer_n.md
PICO_TIMER_N -- requirements
Module: pico_timer_n

Interface
REQ-001 Parameter BASE_ADDRESS, default 8'h00, first port_id of the register window.
REQ-002 Parameter NUM_TIMERS, default 2, channel count, legal 1..4.
REQ-003 Parameter COUNT_WIDTH, default 16, counter width in bits, legal 8/16/24/32.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 port_id  input  8  PicoBlaze port address.
REQ-007 data_in  input  8  write data.
REQ-008 write_strobe  input  1  write qualifier, one cycle.
REQ-009 read_strobe  input  1  read qualifier, one cycle.
REQ-010 data_out  output  8  registered read data.
REQ-011 interrupt  output  1  registered, level, OR of pending enabled channel interrupts.

Function
REQ-012 Channel n occupies BASE_ADDRESS+16n+k: k=0 CTRL, 1 STATUS, 2..5 RELOAD bytes 0..3, 6..9 COUNT bytes 0..3; PRESCALE at BASE_ADDRESS+16*NUM_TIMERS.
REQ-013 CTRL bits: [0] enable, [1] irq_en, [2] periodic (1) / one-shot (0), [3] load (write-only, self-clearing, reads 0), [7:4] read 0.
REQ-014 STATUS bits: [0] expired (sticky, write 1 to clear), [1] running (= enable, read-only), [7:2] read 0.
REQ-015 Writes occur when write_strobe is high and port_id matches; RELOAD/COUNT bytes at or above COUNT_WIDTH/8 ignore writes and read 0; COUNT is read-only.
REQ-016 A shared tick pulses once every PRESCALE+1 clk cycles; the prescaler counter restarts from 0 on any PRESCALE write.
REQ-017 On a tick with enable=1 and count!=0: count decrements by 1.
REQ-018 On a tick with enable=1 and count==0: expired set; periodic then count<=RELOAD; one-shot then enable cleared, count holds 0.
REQ-019 Writing CTRL with bit3=1 loads RELOAD into count that cycle; a coincident tick is ignored for that channel (no decrement, no expiry).
REQ-020 RELOAD=0 in periodic mode: expired asserts on every tick.
REQ-021 Expiry and STATUS write-1-to-clear in the same cycle: expired remains set.
REQ-022 interrupt is asserted the cycle after any channel has expired=1 and irq_en=1; it deasserts the cycle after the last such condition clears.
REQ-023 data_out is updated every cycle from port_id (read latency 1 clk); unmapped addresses return 8'h00.
REQ-024 read_strobe at COUNT byte 0 copies the full live count into a per-channel snapshot; byte 0 returns live byte 0; bytes 1..3 always return the snapshot.
REQ-025 Clearing enable freezes count; setting enable resumes from the frozen value without reload.

Reset
REQ-026 On reset low: all CTRL, STATUS, RELOAD, count, snapshot, PRESCALE and prescaler counter registers become 0, and data_out and interrupt become 0, immediately and asynchronously.
REQ-027 The first tick after reset release occurs PRESCALE+1 cycles after the release edge; reset asserted mid-count abandons the count with no expiry.

Configuration
REQ-028 Macro PICO_TIMER_PRESCALER_EN defined: PRESCALE register and prescaler are present per REQ-016.
REQ-029 Macro PICO_TIMER_PRESCALER_EN undefined: tick is constant 1 (every cycle), PRESCALE address reads 8'h00, and writes to it are ignored.

Verification
REQ-030 Ch0 RELOAD=5, CTRL=8'h0D (enable, periodic, load), PRESCALE=0 -> count 5,4,3,2,1,0, expired on the 6th tick, reload to 5, period 6 cycles.
REQ-031 Ch1 RELOAD=3, CTRL=8'h0B (enable, irq_en, one-shot, load) -> expired and, one cycle later, interrupt=1; STATUS reads 8'h01, count holds 0; write STATUS=8'h01 -> interrupt=0 next cycle.
REQ-032 PRESCALE=3, ch0 RELOAD=2 periodic -> expired pulses every 12 clk; the macro undefined build gives every 3 clk.
REQ-033 Ch0 count=16'h1200 running: read byte0 then byte1 four cycles later -> byte1 returns 8'h12 from the snapshot, not the live count.
REQ-034 RELOAD=0 periodic with STATUS=8'h01 written on an expiry cycle -> expired stays 1.
REQ-035 Assert reset during a count of 16'h00FF -> all outputs 0 asynchronously; after release, STATUS and CTRL read 8'h00.
